// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the debug-link loader: command bytes, program terminator and FSM states.
package mips_dbg_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h4C;
  localparam logic [7:0] CMD_RUN   = 8'h43;
  localparam logic [7:0] CMD_STEP  = 8'h53;
  localparam logic [7:0] CMD_NEXT  = 8'h4E;
  localparam logic [7:0] CMD_ABORT = 8'h58;

  localparam logic [31:0] HALT_INSTR_DEFAULT = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_LOAD       = 3'd1,
    ST_WRITE      = 3'd2,
    ST_RUN_RST    = 3'd3,
    ST_RUN        = 3'd4,
    ST_STEP_RST   = 3'd5,
    ST_STEP_WAIT  = 3'd6,
    ST_STEP_PULSE = 3'd7
  } state_e;

endpackage

// File: rtl/word_assembler.sv
// Packs an MSB-first byte stream into 32-bit words; o_word_valid marks the cycle of the 4th byte.
module word_assembler (
  input  logic        i_clk,
  input  logic        i_clear,
  input  logic [7:0]  i_byte,
  input  logic        i_byte_valid,
  output logic [31:0] o_word,
  output logic        o_word_valid
);

  logic [23:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (i_byte_valid) begin
      shift_d = {shift_q[15:0], i_byte};
      cnt_d   = cnt_q + 2'd1;
    end else begin
      shift_d = shift_q;
      cnt_d   = cnt_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      shift_q <= 24'd0;
      cnt_q   <= 2'd0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // The word completes combinationally with the 4th byte; the counter wraps to 0 on its own.
  assign o_word       = {shift_q, i_byte};
  assign o_word_valid = i_byte_valid && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_load_ctrl.sv
// Debug-link loader: decodes UART commands, writes program words to imem, then runs or steps the pipeline.
// Optional inter-byte load timeout is enabled with `define IMEM_LOAD_TIMEOUT_EN.
module imem_load_ctrl
  import mips_dbg_pkg::*;
#(
  parameter int BITS_SIZE = 32,
  parameter int SIZE_TOTAL = 256,
  parameter logic [BITS_SIZE-1:0] HALT_INSTR = BITS_SIZE'(HALT_INSTR_DEFAULT),
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [7:0]           i_rx_data,
  input  logic                 i_rx_valid,
  input  logic                 i_halt_done,
  output logic [BITS_SIZE-1:0] o_instruction_address,
  output logic [BITS_SIZE-1:0] o_instruction,
  output logic                 o_flag_write_intruc,
  output logic                 o_step,
  output logic                 o_pipe_reset,
  output logic                 o_loaded,
  output logic                 o_load_err,
  output logic                 o_busy
);

  state_e                state_q, state_d;
  logic [BITS_SIZE-1:0]  addr_q, addr_d;
  logic [BITS_SIZE-1:0]  instr_q, instr_d;
  logic                  wr_q, wr_d;
  logic                  loaded_q, loaded_d;
  logic                  err_q, err_d;

  logic        asm_clear_s;
  logic        asm_valid_s;
  logic [31:0] word_s;
  logic        word_valid_s;
  logic        timeout_s;

  // Bytes arriving during WRITE belong to the next word, so the assembler listens in both states.
  assign asm_valid_s = i_rx_valid && ((state_q == ST_LOAD) || (state_q == ST_WRITE));

  word_assembler u_asm (
    .i_clk        (i_clk),
    .i_clear      (i_reset || asm_clear_s),
    .i_byte       (i_rx_data),
    .i_byte_valid (asm_valid_s),
    .o_word       (word_s),
    .o_word_valid (word_valid_s)
  );

`ifdef IMEM_LOAD_TIMEOUT_EN
  logic [31:0] tmo_q;

  always_ff @(posedge i_clk) begin
    if (i_reset || (state_q != ST_LOAD) || i_rx_valid) begin
      tmo_q <= 32'd0;
    end else begin
      tmo_q <= tmo_q + 32'd1;
    end
  end

  assign timeout_s = (state_q == ST_LOAD) && !i_rx_valid &&
                     (tmo_q == 32'(TIMEOUT_CYCLES - 32'd1));
`else
  assign timeout_s = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    instr_d     = instr_q;
    wr_d        = 1'b0;
    loaded_d    = loaded_q;
    err_d       = err_q;
    asm_clear_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_rx_valid && (i_rx_data == CMD_LOAD)) begin
          state_d     = ST_LOAD;
          addr_d      = '0;
          loaded_d    = 1'b0;
          err_d       = 1'b0;
          asm_clear_s = 1'b1;
        end else if (i_rx_valid && (i_rx_data == CMD_RUN) && loaded_q) begin
          state_d = ST_RUN_RST;
        end else if (i_rx_valid && (i_rx_data == CMD_STEP) && loaded_q) begin
          state_d = ST_STEP_RST;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (word_valid_s) begin
          state_d = ST_WRITE;
          wr_d    = 1'b1;
          instr_d = BITS_SIZE'(word_s);
        end else if (timeout_s) begin
          state_d     = ST_IDLE;
          err_d       = 1'b1;
          asm_clear_s = 1'b1;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_WRITE: begin
        if (instr_q == HALT_INSTR) begin
          state_d  = ST_IDLE;
          loaded_d = 1'b1;
        end else if ((addr_q + BITS_SIZE'(32'd4)) == BITS_SIZE'(SIZE_TOTAL)) begin
          // Memory full without a terminator: flag it rather than wrapping over word 0.
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          state_d = ST_LOAD;
          addr_d  = addr_q + BITS_SIZE'(32'd4);
        end
      end
      ST_RUN_RST: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (i_halt_done) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_STEP_RST: begin
        state_d = ST_STEP_WAIT;
      end
      ST_STEP_WAIT: begin
        if (i_halt_done) begin
          state_d = ST_IDLE;
        end else if (i_rx_valid && (i_rx_data == CMD_ABORT)) begin
          state_d = ST_IDLE;
        end else if (i_rx_valid && (i_rx_data == CMD_NEXT)) begin
          state_d = ST_STEP_PULSE;
        end else begin
          state_d = ST_STEP_WAIT;
        end
      end
      ST_STEP_PULSE: begin
        state_d = ST_STEP_WAIT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      instr_q  <= '0;
      wr_q     <= 1'b0;
      loaded_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      instr_q  <= instr_d;
      wr_q     <= wr_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
    end
  end

  // Step is gated by i_halt_done directly so the pipeline never advances past the retired HALT.
  assign o_step                = ((state_q == ST_RUN) && !i_halt_done) || (state_q == ST_STEP_PULSE);
  assign o_pipe_reset          = (state_q == ST_RUN_RST) || (state_q == ST_STEP_RST);
  assign o_busy                = (state_q != ST_IDLE);
  assign o_instruction_address = addr_q;
  assign o_instruction         = instr_q;
  assign o_flag_write_intruc   = wr_q;
  assign o_loaded              = loaded_q;
  assign o_load_err            = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Directed self-checking bench for imem_load_ctrl (optionally built with IMEM_LOAD_TIMEOUT_EN).
module tb_imem_load_ctrl;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_halt_done = 1'b0;
  logic [31:0] o_instruction_address;
  logic [31:0] o_instruction;
  logic        o_flag_write_intruc;
  logic        o_step;
  logic        o_pipe_reset;
  logic        o_loaded;
  logic        o_load_err;
  logic        o_busy;

  int n_assert = 0;
  int n_fail = 0;

  int          wr_cnt = 0;
  logic [31:0] wr_addr [0:127];
  logic [31:0] wr_data [0:127];
  int          step_cnt = 0;
  int          prst_cnt = 0;

  always #5 clk = ~clk;

  imem_load_ctrl #(.TIMEOUT_CYCLES(100)) dut (
    .i_clk                 (clk),
    .i_reset               (i_reset),
    .i_rx_data             (i_rx_data),
    .i_rx_valid            (i_rx_valid),
    .i_halt_done           (i_halt_done),
    .o_instruction_address (o_instruction_address),
    .o_instruction         (o_instruction),
    .o_flag_write_intruc   (o_flag_write_intruc),
    .o_step                (o_step),
    .o_pipe_reset          (o_pipe_reset),
    .o_loaded              (o_loaded),
    .o_load_err            (o_load_err),
    .o_busy                (o_busy)
  );

  // Record every imem write and count step / pipe-reset cycles, sampled mid-cycle.
  always @(negedge clk) begin
    #2;
    if (o_flag_write_intruc) begin
      if (wr_cnt < 128) begin
        wr_addr[wr_cnt] = o_instruction_address;
        wr_data[wr_cnt] = o_instruction;
      end
      wr_cnt = wr_cnt + 1;
    end
    if (o_step) step_cnt = step_cnt + 1;
    if (o_pipe_reset) prst_cnt = prst_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    i_rx_valid = 1'b1;
    i_rx_data  = b;
    #1;
  endtask

  task automatic gap();
    @(negedge clk);
    i_rx_valid = 1'b0;
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] w);
    put(w[31:24]); put(w[23:16]); put(w[15:8]); put(w[7:0]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_reset = 1'b1;
    i_rx_valid = 1'b0;
    i_halt_done = 1'b0;
    idle(2);
    @(negedge clk);
    i_reset = 1'b0;
    #1;
  endtask

  initial begin
    int base_wr;
    int base_step;
    int base_prst;
    int run_steps;
    logic [31:0] v;

    // Reset values
    do_reset();
    check("rst_addr",   o_instruction_address, 32'h0);
    check("rst_instr",  o_instruction, 32'h0);
    check("rst_wr",     {31'd0, o_flag_write_intruc}, 32'd0);
    check("rst_step",   {31'd0, o_step}, 32'd0);
    check("rst_prst",   {31'd0, o_pipe_reset}, 32'd0);
    check("rst_loaded", {31'd0, o_loaded}, 32'd0);
    check("rst_err",    {31'd0, o_load_err}, 32'd0);
    check("rst_busy",   {31'd0, o_busy}, 32'd0);

    // 1: two-word program with gaps between bytes
    base_wr = wr_cnt;
    put(8'h4C); gap();
    check("t1_busy_load", {31'd0, o_busy}, 32'd1);
    put(8'h00); gap(); put(8'h00); gap(); put(8'h00); gap(); put(8'h01); gap();
    put(8'hFF); gap(); put(8'hFF); gap(); put(8'hFF); gap(); put(8'hFF); gap();
    idle(2);
    check("t1_wr_cnt", 32'(wr_cnt - base_wr), 32'd2);
    check("t1_addr0",  wr_addr[base_wr], 32'h0);
    check("t1_data0",  wr_data[base_wr], 32'h0000_0001);
    check("t1_addr1",  wr_addr[base_wr + 1], 32'h4);
    check("t1_data1",  wr_data[base_wr + 1], 32'hFFFF_FFFF);
    check("t1_loaded", {31'd0, o_loaded}, 32'd1);
    check("t1_busy",   {31'd0, o_busy}, 32'd0);

    // 2: 64 non-HALT words streamed back to back (bytes also land during WRITE)
    base_wr = wr_cnt;
    put(8'h4C);
    for (int w = 0; w < 64; w++) begin
      v = 32'(w + 1);
      put_word(v);
    end
    gap();
    idle(3);
    check("t2_wr_cnt", 32'(wr_cnt - base_wr), 32'd64);
    check("t2_addr10", wr_addr[base_wr + 10], 32'd40);
    check("t2_data10", wr_data[base_wr + 10], 32'd11);
    check("t2_addr63", wr_addr[base_wr + 63], 32'd252);
    check("t2_data63", wr_data[base_wr + 63], 32'd64);
    check("t2_err",    {31'd0, o_load_err}, 32'd1);
    check("t2_loaded", {31'd0, o_loaded}, 32'd0);
    check("t2_busy",   {31'd0, o_busy}, 32'd0);

    // 3: load a program, then continuous run
    put(8'h4C); put_word(32'h1111_1111); put_word(32'h2222_2222); put_word(32'hFFFF_FFFF); gap();
    idle(2);
    check("t3_err_clr", {31'd0, o_load_err}, 32'd0);
    check("t3_loaded",  {31'd0, o_loaded}, 32'd1);
    base_prst = prst_cnt;
    put(8'h43); gap();
    check("t3_prst",      {31'd0, o_pipe_reset}, 32'd1);
    check("t3_step_rst",  {31'd0, o_step}, 32'd0);
    idle(1);
    check("t3_prst_off",  {31'd0, o_pipe_reset}, 32'd0);
    run_steps = o_step ? 1 : 0;
    for (int c = 2; c < 20; c++) begin
      idle(1);
      if (o_step) run_steps++;
    end
    check("t3_run_steps", 32'(run_steps), 32'd19);
    @(negedge clk);
    i_halt_done = 1'b1;
    #1;
    check("t3_step_halt", {31'd0, o_step}, 32'd0);
    check("t3_busy_halt", {31'd0, o_busy}, 32'd1);
    @(negedge clk);
    i_halt_done = 1'b0;
    #1;
    check("t3_busy_after", {31'd0, o_busy}, 32'd0);
    check("t3_prst_count", 32'(prst_cnt - base_prst), 32'd1);

    // 4: single-step mode
    base_step = step_cnt;
    base_prst = prst_cnt;
    put(8'h53); gap();
    check("t4_prst", {31'd0, o_pipe_reset}, 32'd1);
    idle(3);
    check("t4_wait_step", {31'd0, o_step}, 32'd0);
    check("t4_wait_busy", {31'd0, o_busy}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      put(8'h4E); gap(); idle(2);
    end
    check("t4_steps", 32'(step_cnt - base_step), 32'd3);
    @(negedge clk);
    i_halt_done = 1'b1;
    @(negedge clk);
    i_halt_done = 1'b0;
    #1;
    check("t4_halt_idle", {31'd0, o_busy}, 32'd0);
    put(8'h4E); gap(); idle(2);
    check("t4_idle_n", 32'(step_cnt - base_step), 32'd3);
    put(8'h53); gap(); idle(1);
    put(8'h58); gap();
    check("t4_abort", {31'd0, o_busy}, 32'd0);
    check("t4_prst_count", 32'(prst_cnt - base_prst), 32'd2);

    // 5: reset clears o_loaded, run refused, partial word discarded
    do_reset();
    check("t5_loaded_rst", {31'd0, o_loaded}, 32'd0);
    base_step = step_cnt;
    base_prst = prst_cnt;
    put(8'h43); gap(); idle(3);
    check("t5_busy",  {31'd0, o_busy}, 32'd0);
    check("t5_steps", 32'(step_cnt - base_step), 32'd0);
    check("t5_prst",  32'(prst_cnt - base_prst), 32'd0);
    put(8'h4C); put(8'hAA); put(8'hBB); gap();
    do_reset();
    base_wr = wr_cnt;
    put(8'h4C); put_word(32'h1234_5678); gap(); idle(2);
    check("t5_wr_cnt", 32'(wr_cnt - base_wr), 32'd1);
    check("t5_addr",   wr_addr[base_wr], 32'h0);
    check("t5_data",   wr_data[base_wr], 32'h1234_5678);
    check("t5_in_load", {31'd0, o_busy}, 32'd1);

    // 6: silence in the middle of a word
    do_reset();
    base_wr = wr_cnt;
    put(8'h4C); put(8'h01); put(8'h02); gap();
    idle(90);
    check("t6_err_early", {31'd0, o_load_err}, 32'd0);
    idle(20);
`ifdef IMEM_LOAD_TIMEOUT_EN
    check("t6_err",  {31'd0, o_load_err}, 32'd1);
    check("t6_busy", {31'd0, o_busy}, 32'd0);
`else
    check("t6_err",  {31'd0, o_load_err}, 32'd0);
    check("t6_busy", {31'd0, o_busy}, 32'd1);
`endif
    check("t6_no_write", 32'(wr_cnt - base_wr), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
